// File: rtl/branch_predictor.sv
// Branch prediction unit: tagged direct-mapped BHT with 2-bit counters, optional return
// address stack (BPU_RAS_EN), and a correction-redirect FSM driven by ID-stage verify.
module branch_predictor #(
  parameter int BHT_ENTRIES = 64,
  parameter int RAS_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        vfy_valid,
  input  logic [31:0] vfy_pc,
  input  logic [2:0]  vfy_br_type,
  input  logic        vfy_taken,
  input  logic [31:0] vfy_target,
  input  logic        vfy_pred_taken,
  input  logic [31:0] vfy_pred_target,
  input  logic        flush,
  output logic        corr_valid,
  output logic [31:0] corr_target,
  input  logic        corr_ack
);

  localparam int IW = $clog2(BHT_ENTRIES);
  localparam int RW = $clog2(RAS_DEPTH);

  localparam logic [2:0] B_IS_J    = 3'd1;
  localparam logic [2:0] B_IS_CALL = 3'd2;
  localparam logic [2:0] B_IS_RET  = 3'd3;
  localparam logic [2:0] B_IS_BRA  = 3'd4;

  typedef enum logic {IDLE = 1'b0, CORRECTION = 1'b1} state_t;

  logic        r_bht_valid  [BHT_ENTRIES];
  logic [21:0] r_bht_tag    [BHT_ENTRIES];
  logic [31:0] r_bht_target [BHT_ENTRIES];
  logic [2:0]  r_bht_type   [BHT_ENTRIES];
  logic [1:0]  r_bht_count  [BHT_ENTRIES];

  logic          r_pred_valid;
  logic          r_pred_taken;
  logic [31:0]   r_pred_target;
  state_t        r_state, w_state_nxt;
  logic [31:0]   r_corr_target, w_corr_target_nxt;

  logic [IW-1:0] w_ridx, w_vidx;
  logic          w_rhit, w_vhit, w_mispredict;
  logic          w_ptaken;
  logic [31:0]   w_ptarget, w_ret_target;
  logic          w_unused_pc;

  assign w_ridx      = req_pc[IW+1:2];
  assign w_vidx      = vfy_pc[IW+1:2];
  assign w_rhit      = r_bht_valid[w_ridx] && (r_bht_tag[w_ridx] == req_pc[31:10]);
  assign w_vhit      = r_bht_valid[w_vidx] && (r_bht_tag[w_vidx] == vfy_pc[31:10]);
  assign w_unused_pc = &{1'b0, req_pc, vfy_pc};

`ifdef BPU_RAS_EN
  logic [31:0] r_ras [RAS_DEPTH];
  logic [RW-1:0] r_ras_ptr;
  logic [RW:0]   r_ras_cnt;
  logic [RW-1:0] w_ras_top_ptr;

  assign w_ras_top_ptr = r_ras_ptr - RW'(1);
  assign w_ret_target  = (r_ras_cnt != '0) ? r_ras[w_ras_top_ptr] : r_bht_target[w_ridx];

  // r_ras_ptr is the next free slot; a push when full wraps and overwrites the oldest entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ras_ptr <= '0;
      r_ras_cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
    end else if (vfy_valid) begin
      if (vfy_br_type == B_IS_CALL) begin
        r_ras[r_ras_ptr] <= vfy_pc + 32'd8;
        r_ras_ptr        <= r_ras_ptr + RW'(1);
        if (r_ras_cnt != (RW+1)'(RAS_DEPTH)) r_ras_cnt <= r_ras_cnt + (RW+1)'(1);
      end else if (vfy_br_type == B_IS_RET && r_ras_cnt != '0) begin
        r_ras_ptr <= r_ras_ptr - RW'(1);
        r_ras_cnt <= r_ras_cnt - (RW+1)'(1);
      end
    end
  end
`else
  assign w_ret_target = r_bht_target[w_ridx];
`endif

  always_comb begin
    w_ptaken  = 1'b0;
    w_ptarget = 32'd0;
    if (w_rhit) begin
      case (r_bht_type[w_ridx])
        B_IS_J, B_IS_CALL: begin w_ptaken = 1'b1; w_ptarget = r_bht_target[w_ridx]; end
        B_IS_RET:          begin w_ptaken = 1'b1; w_ptarget = w_ret_target; end
        B_IS_BRA:          begin w_ptaken = r_bht_count[w_ridx][1]; w_ptarget = r_bht_target[w_ridx]; end
        default:           begin w_ptaken = 1'b0; w_ptarget = 32'd0; end
      endcase
    end
  end

  // Lookup reads the arrays before this edge's update lands, so same-index collisions see old data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pred_valid  <= 1'b0;
      r_pred_taken  <= 1'b0;
      r_pred_target <= 32'd0;
    end else begin
      r_pred_valid  <= req_valid;
      r_pred_taken  <= w_ptaken;
      r_pred_target <= w_ptarget;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        r_bht_valid[i]  <= 1'b0;
        r_bht_tag[i]    <= '0;
        r_bht_target[i] <= '0;
        r_bht_type[i]   <= '0;
        r_bht_count[i]  <= 2'b00;
      end
    end else if (vfy_valid) begin
      case (vfy_br_type)
        B_IS_J, B_IS_CALL, B_IS_RET: begin
          r_bht_valid[w_vidx]  <= 1'b1;
          r_bht_tag[w_vidx]    <= vfy_pc[31:10];
          r_bht_target[w_vidx] <= vfy_target;
          r_bht_type[w_vidx]   <= vfy_br_type;
          r_bht_count[w_vidx]  <= 2'b11;
        end
        B_IS_BRA: begin
          if (w_vhit) begin
            if (vfy_taken) begin
              r_bht_target[w_vidx] <= vfy_target;
              if (r_bht_count[w_vidx] != 2'b11) r_bht_count[w_vidx] <= r_bht_count[w_vidx] + 2'd1;
            end else if (r_bht_count[w_vidx] != 2'b00) begin
              r_bht_count[w_vidx] <= r_bht_count[w_vidx] - 2'd1;
            end
          end else if (vfy_taken) begin
            r_bht_valid[w_vidx]  <= 1'b1;
            r_bht_tag[w_vidx]    <= vfy_pc[31:10];
            r_bht_target[w_vidx] <= vfy_target;
            r_bht_type[w_vidx]   <= B_IS_BRA;
            r_bht_count[w_vidx]  <= 2'b10;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_mispredict = vfy_valid && ((vfy_taken != vfy_pred_taken) ||
                                      (vfy_taken && (vfy_target != vfy_pred_target)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_corr_target <= 32'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_corr_target <= w_corr_target_nxt;
    end
  end

  // flush wins over everything; a fresh mispredict wins over an ack in the same cycle.
  always_comb begin
    w_state_nxt       = r_state;
    w_corr_target_nxt = r_corr_target;
    if (flush) begin
      w_state_nxt = IDLE;
    end else if (w_mispredict) begin
      w_state_nxt       = CORRECTION;
      w_corr_target_nxt = vfy_taken ? vfy_target : (vfy_pc + 32'd8);
    end else if (r_state == CORRECTION && corr_ack) begin
      w_state_nxt = IDLE;
    end
  end

  assign pred_valid  = r_pred_valid;
  assign pred_taken  = r_pred_taken;
  assign pred_target = r_pred_target;
  assign corr_valid  = (r_state == CORRECTION);
  assign corr_target = r_corr_target;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor; RET expectations follow the BPU_RAS_EN build option.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        pred_valid, pred_taken;
  logic [31:0] pred_target;
  logic        vfy_valid;
  logic [31:0] vfy_pc;
  logic [2:0]  vfy_br_type;
  logic        vfy_taken;
  logic [31:0] vfy_target;
  logic        vfy_pred_taken;
  logic [31:0] vfy_pred_target;
  logic        flush;
  logic        corr_valid;
  logic [31:0] corr_target;
  logic        corr_ack;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_t;

  localparam logic [31:0] RPC  = 32'h8000_2004;
  localparam logic [31:0] RTGT = 32'h9000_0000;

  branch_predictor dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_pc(req_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .vfy_valid(vfy_valid), .vfy_pc(vfy_pc), .vfy_br_type(vfy_br_type),
    .vfy_taken(vfy_taken), .vfy_target(vfy_target),
    .vfy_pred_taken(vfy_pred_taken), .vfy_pred_target(vfy_pred_target),
    .flush(flush), .corr_valid(corr_valid), .corr_target(corr_target), .corr_ack(corr_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    req_valid = 0; req_pc = 0; vfy_valid = 0; vfy_pc = 0; vfy_br_type = 0;
    vfy_taken = 0; vfy_target = 0; vfy_pred_taken = 0; vfy_pred_target = 0;
    flush = 0; corr_ack = 0;
  endtask

  task automatic cycle();
    @(posedge clk); #1; clr();
  endtask

  task automatic set_vfy(input logic [31:0] pc, input logic [2:0] ty, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    vfy_valid = 1; vfy_pc = pc; vfy_br_type = ty; vfy_taken = tk;
    vfy_target = tgt; vfy_pred_taken = ptk; vfy_pred_target = ptgt;
  endtask

  task automatic vfy_ok(input logic [31:0] pc, input logic [2:0] ty, input logic tk, input logic [31:0] tgt);
    set_vfy(pc, ty, tk, tgt, tk, tgt);
    cycle();
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic etk, input logic [31:0] etgt);
    req_valid = 1; req_pc = pc;
    cycle();
    chk({tag, "_pv"}, {31'd0, pred_valid}, 32'd1);
    chk({tag, "_tk"}, {31'd0, pred_taken}, {31'd0, etk});
    chk({tag, "_tgt"}, pred_target, etgt);
  endtask

  initial begin
    clr();
    reset = 1;
    #2;
    chk("rst_pv", {31'd0, pred_valid}, 32'd0);
    chk("rst_ptk", {31'd0, pred_taken}, 32'd0);
    chk("rst_ptgt", pred_target, 32'd0);
    chk("rst_cv", {31'd0, corr_valid}, 32'd0);
    chk("rst_ctgt", corr_target, 32'd0);
    @(posedge clk); #1; reset = 0;
    cycle();
    chk("idle_pv", {31'd0, pred_valid}, 32'd0);

    lookup("miss0", 32'hBFC0_0100, 1'b0, 32'd0);
    chk("miss0_cv", {31'd0, corr_valid}, 32'd0);

    // BRA taken miss, mispredicted -> allocate WT and redirect
    set_vfy(32'hBFC0_0200, 3'd4, 1'b1, 32'hBFC0_0300, 1'b0, 32'd0);
    cycle();
    chk("bra_cv1", {31'd0, corr_valid}, 32'd1);
    chk("bra_ctgt1", corr_target, 32'hBFC0_0300);
    cycle();
    chk("bra_cv_hold", {31'd0, corr_valid}, 32'd1);
    chk("bra_ctgt_hold", corr_target, 32'hBFC0_0300);
    corr_ack = 1;
    cycle();
    chk("bra_cv_ack", {31'd0, corr_valid}, 32'd0);
    lookup("bra_wt", 32'hBFC0_0200, 1'b1, 32'hBFC0_0300);

    // Counter walk: WT -> 01 -> 00 -> 00 -> 01 -> 10
    vfy_ok(32'hBFC0_0200, 3'd4, 1'b0, 32'd0);
    lookup("bra_01", 32'hBFC0_0200, 1'b0, 32'hBFC0_0300);
    vfy_ok(32'hBFC0_0200, 3'd4, 1'b0, 32'd0);
    lookup("bra_00", 32'hBFC0_0200, 1'b0, 32'hBFC0_0300);
    vfy_ok(32'hBFC0_0200, 3'd4, 1'b0, 32'd0);
    vfy_ok(32'hBFC0_0200, 3'd4, 1'b1, 32'hBFC0_0300);
    lookup("bra_sat01", 32'hBFC0_0200, 1'b0, 32'hBFC0_0300);
    vfy_ok(32'hBFC0_0200, 3'd4, 1'b1, 32'hBFC0_0400);
    lookup("bra_10", 32'hBFC0_0200, 1'b1, 32'hBFC0_0400);
    chk("bra_cv_none", {31'd0, corr_valid}, 32'd0);

    // RET entry allocated with empty stack, then CALL/RET pairing
    vfy_ok(RPC, 3'd3, 1'b1, RTGT);
    lookup("ret_empty", RPC, 1'b1, RTGT);
    vfy_ok(32'h8000_1000, 3'd2, 1'b1, 32'h8000_4000);
    lookup("call_hit", 32'h8000_1000, 1'b1, 32'h8000_4000);
`ifdef BPU_RAS_EN
    exp_t = 32'h8000_1008;
`else
    exp_t = RTGT;
`endif
    lookup("ret_top1", RPC, 1'b1, exp_t);
    vfy_ok(RPC, 3'd3, 1'b1, RTGT);

    // Nine calls overflow an 8-deep stack; eight pops then expose the BHT target
    for (int k = 0; k < 9; k++) vfy_ok(32'h8000_1000 + 32'(k * 16), 3'd2, 1'b1, 32'h8000_4000);
    for (int j = 0; j < 8; j++) begin
`ifdef BPU_RAS_EN
      exp_t = 32'h8000_1008 + 32'((8 - j) * 16);
`else
      exp_t = RTGT;
`endif
      lookup($sformatf("ras_pop%0d", j), RPC, 1'b1, exp_t);
      vfy_ok(RPC, 3'd3, 1'b1, RTGT);
    end
    lookup("ras_empty", RPC, 1'b1, RTGT);
    vfy_ok(RPC, 3'd3, 1'b1, RTGT);
    vfy_ok(32'h8000_1100, 3'd2, 1'b1, 32'h8000_4000);
`ifdef BPU_RAS_EN
    exp_t = 32'h8000_1108;
`else
    exp_t = RTGT;
`endif
    lookup("ras_after_uf", RPC, 1'b1, exp_t);

    // Mispredict with flush in the same cycle: no redirect, table still updated
    set_vfy(32'h8000_6000, 3'd4, 1'b1, 32'h8000_7000, 1'b0, 32'd0);
    flush = 1;
    cycle();
    chk("flush_same_cv", {31'd0, corr_valid}, 32'd0);
    lookup("flush_upd", 32'h8000_6000, 1'b1, 32'h8000_7000);

    // Target mismatch, then flush during CORRECTION
    set_vfy(32'h8000_8000, 3'd1, 1'b1, 32'h8000_9000, 1'b1, 32'h8000_9004);
    cycle();
    chk("tgt_mis_cv", {31'd0, corr_valid}, 32'd1);
    chk("tgt_mis_ctgt", corr_target, 32'h8000_9000);
    flush = 1;
    corr_ack = 1;
    cycle();
    chk("flush_corr_cv", {31'd0, corr_valid}, 32'd0);

    // Not-taken mispredict, replacement while pending, ack+mispredict together
    set_vfy(32'h8000_A000, 3'd4, 1'b0, 32'd0, 1'b1, 32'h8000_A100);
    cycle();
    chk("nt_mis_cv", {31'd0, corr_valid}, 32'd1);
    chk("nt_mis_ctgt", corr_target, 32'h8000_A008);
    set_vfy(32'h8000_B000, 3'd4, 1'b1, 32'h8000_C000, 1'b0, 32'd0);
    cycle();
    chk("repl_cv", {31'd0, corr_valid}, 32'd1);
    chk("repl_ctgt", corr_target, 32'h8000_C000);
    set_vfy(32'h8000_D000, 3'd1, 1'b1, 32'h8000_E000, 1'b0, 32'd0);
    corr_ack = 1;
    cycle();
    chk("ackmis_cv", {31'd0, corr_valid}, 32'd1);
    chk("ackmis_ctgt", corr_target, 32'h8000_E000);
    corr_ack = 1;
    cycle();
    chk("ack_cv", {31'd0, corr_valid}, 32'd0);
    lookup("nt_noalloc", 32'h8000_A000, 1'b0, 32'd0);

    // Same-cycle lookup and update to one index
    req_valid = 1; req_pc = 32'h8000_3008;
    vfy_ok(32'h8000_3008, 3'd1, 1'b1, 32'h8000_5000);
    chk("coll_pv", {31'd0, pred_valid}, 32'd1);
    chk("coll_tk_old", {31'd0, pred_taken}, 32'd0);
    chk("coll_tgt_old", pred_target, 32'd0);
    lookup("coll_new", 32'h8000_3008, 1'b1, 32'h8000_5000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Branch prediction unit that sits beside pre-IF/IF, on the opposite end of the ID-stage verify path.
- Predicts fetch redirects from a tagged BHT with 2-bit counters and a return address stack.
- Consumes the resolved branch outcome from ID, updates its tables, and issues a correction redirect to pre-IF on a misprediction.

Parameters:
- BHT_ENTRIES, 64, number of direct-mapped BHT entries (power of 2); index = pc[log2(BHT_ENTRIES)+1:2]
- RAS_DEPTH, 8, return address stack entries (power of 2)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  pre-IF lookup request valid
- req_pc  in  32  pre-IF fetch pc
- pred_valid  out  1  prediction valid (for request of previous cycle)
- pred_taken  out  1  predicted taken
- pred_target  out  32  predicted target
- vfy_valid  in  1  ID resolved a branch this cycle
- vfy_pc  in  32  branch pc
- vfy_br_type  in  3  B_IS_J=1, B_IS_CALL=2, B_IS_RET=3, B_IS_BRA=4
- vfy_taken  in  1  actual direction
- vfy_target  in  32  actual taken target
- vfy_pred_taken  in  1  direction predicted for this branch
- vfy_pred_target  in  32  target predicted for this branch
- flush  in  1  pipeline flush (exception/eret/tlb refill)
- corr_valid  out  1  correction redirect pending
- corr_target  out  32  correction pc
- corr_ack  in  1  pre-IF accepted correction

Behaviour:
- Reset (async): all BHT valid bits 0, counters NT (2'b00), RAS pointer/count 0, state IDLE, pred_valid/pred_taken/corr_valid 0, pred_target/corr_target 0.
- BHT entry contents: valid, tag = pc[31:10], target[31:0], br_type[2:0], count[1:0].
- Lookup latency 1:
  - pred_* registered from req_pc; pred_valid = req_valid delayed one cycle.
  - Same-cycle lookup and update to the same index: lookup sees the pre-update contents.
- Prediction on hit (valid && tag match):
  - J/CALL: taken, target = stored target.
  - RET: taken, target = RAS top if RAS count>0, else stored target.
  - BRA: taken = count[1], target = stored target.
  - Miss: taken=0, target=0.
- Update on vfy_valid:
  - BRA hit: saturating counter, +1 toward T (2'b11) if taken, −1 toward NT (2'b00) if not.
  - BRA hit, taken: target rewritten with vfy_target.
  - BRA miss: allocate only if taken, with count=WT (2'b10); a not-taken miss does not allocate.
  - J/CALL/RET: always allocate or overwrite, count=T.
  - Allocation overwrites the indexed entry unconditionally.
- RAS updates on vfy_valid:
  - CALL pushes vfy_pc+8 (mod 2^32).
  - RET pops.
  - Push when full overwrites the oldest entry (pointer wraps at RAS_DEPTH); count saturates at RAS_DEPTH.
  - Pop when empty leaves the RAS unchanged.
- Mispredict = vfy_valid && (vfy_taken != vfy_pred_taken || (vfy_taken && vfy_target != vfy_pred_target)).
- Correction FSM, states IDLE (`IDLE`=0) and CORRECTION (`CORRECTION`=1):
  - IDLE → CORRECTION on mispredict. corr_target = vfy_taken ? vfy_target : vfy_pc+8.
  - corr_valid = (state==CORRECTION), registered; asserted the cycle after the mispredict.
  - CORRECTION → IDLE on corr_ack.
  - Mispredict while in CORRECTION without ack: corr_target replaced by the newest value, state held.
  - corr_ack and a new mispredict in the same cycle: stay in CORRECTION with the new target.
  - flush in any state: next state IDLE, corr_valid 0. flush beats corr_ack and mispredict.
  - flush does not modify BHT or RAS.
- Table updates occur regardless of FSM state or flush.

Optional Feature:
- Macro BPU_RAS_EN.
- Defined: RAS implemented as above.
- Undefined: no RAS storage; RET predicted from the BHT stored target like J; CALL/RET cause no stack activity.

Test Plan:
- Reset then req_pc=0xBFC00100 → next cycle pred_valid=1, pred_taken=0, pred_target=0; corr_valid=0.
- Verify BRA pc=0xBFC00200, taken, target 0xBFC00300, pred_taken=0 → corr_valid=1 with corr_target=0xBFC00300 until corr_ack. Then lookup 0xBFC00200 → taken, 0xBFC00300, count WT.
- Same BRA verified not-taken twice from WT → counter 01 then 00; lookup → pred_taken=0. Third not-taken stays 00.
- Verify CALL pc=0x80001000, then RET lookup hit → pred_target=0x80001008. Nine CALLs (RAS_DEPTH=8) then eight RETs → first-call address lost, no underflow corruption.
- Mispredict with flush same cycle → corr_valid stays 0. Mispredict, then flush during CORRECTION → corr_valid drops next cycle.
- Lookup and verify to the same index in one cycle → prediction reflects old entry; following lookup reflects the update.
